// File: rtl/tx_fcs_pad.sv
// tx_fcs_pad: Ethernet TX framer stage. Passes frame bytes through one output
// register, optionally zero-pads short frames to MIN_LEN and appends an
// IEEE 802.3 CRC-32 FCS. Reports per-frame completion and emitted length.
module tx_fcs_pad #(
  parameter int MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_eof,
  output logic        in_ready,
  input  logic        cfg_pad_en,
  input  logic        cfg_crc_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_eof,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [10:0] frame_len
);

  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

  state_t      state, state_d;
  logic [10:0] count;
  logic [31:0] crc;
  logic [1:0]  fcs_idx;
  logic        pad_q, crc_q;
  logic [10:0] len_q;

  logic        load, in_xfer, pad_use, crc_use;
  logic [10:0] cnt_base, cnt_inc, len_d;
  logic [31:0] crc_base;
  logic [7:0]  byte_d, fcs_byte;
  logic        eof_d, out_load;

  // Reflected CRC-32 update, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Add that sticks at 2047 instead of wrapping.
  function automatic logic [10:0] sat_add(input logic [10:0] a, input logic [2:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[11] ? 11'h7FF : s[10:0];
  endfunction

  // The output register may take a new byte when empty or being drained.
  assign load     = !out_valid || out_ready;
  assign in_ready = ((state == IDLE) || (state == DATA)) && load;
  assign in_xfer  = in_valid && in_ready;

  // Config comes straight from the ports on the first byte, then from the latch.
  assign pad_use  = (state == IDLE) ? cfg_pad_en : pad_q;
  assign crc_use  = (state == IDLE) ? cfg_crc_en : crc_q;
  assign cnt_base = (state == IDLE) ? 11'd0 : count;
  assign crc_base = (state == IDLE) ? CRC_INIT : crc;
  assign cnt_inc  = sat_add(cnt_base, 3'd1);

  // FCS byte selection, least significant byte of the inverted CRC first.
  always_comb begin
    fcs_byte = 8'h00;
    case (fcs_idx)
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end

  // Next-state and output-register load decode.
  always_comb begin
    state_d  = state;
    byte_d   = in_data;
    eof_d    = 1'b0;
    out_load = 1'b0;
    len_d    = cnt_inc;
    unique case (state)
      IDLE, DATA: begin
        if (in_xfer) begin
          out_load = 1'b1;
          state_d  = DATA;
          if (in_eof) begin
            if (pad_use && (cnt_inc < MIN_L)) state_d = PAD;
            else if (crc_use)                 state_d = FCS;
            else begin
              state_d = IDLE;
              eof_d   = 1'b1;
            end
          end
        end
      end
      PAD: begin
        byte_d = 8'h00;
        if (load) begin
          out_load = 1'b1;
          if (cnt_inc >= MIN_L) begin
            if (crc_q) state_d = FCS;
            else begin
              state_d = IDLE;
              eof_d   = 1'b1;
            end
          end
        end
      end
      FCS: begin
        byte_d = fcs_byte;
        len_d  = sat_add(count, 3'd4);
        if (load) begin
          out_load = 1'b1;
          if (fcs_idx == 2'd3) begin
            state_d = IDLE;
            eof_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Output register, counter, CRC and completion reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_eof    <= 1'b0;
      out_data   <= 8'h00;
      frame_done <= 1'b0;
      frame_len  <= 11'd0;
      count      <= 11'd0;
      crc        <= CRC_INIT;
      fcs_idx    <= 2'd0;
      pad_q      <= 1'b0;
      crc_q      <= 1'b0;
      len_q      <= 11'd0;
    end else begin
      // len_q is only rewritten on the next eof load, which cannot happen
      // before the current eof byte has left the register.
      frame_done <= out_valid && out_ready && out_eof;
      if (out_valid && out_ready && out_eof) frame_len <= len_q;

      if (load) begin
        out_valid <= out_load;
        out_eof   <= out_load && eof_d;
        if (out_load) out_data <= byte_d;
      end

      if (in_xfer && (state == IDLE)) begin
        pad_q <= cfg_pad_en;
        crc_q <= cfg_crc_en;
      end

      // Data and pad bytes feed the CRC; FCS bytes leave it frozen.
      if (in_xfer || ((state == PAD) && load)) begin
        count <= cnt_inc;
        crc   <= crc_byte(crc_base, byte_d);
      end

      if ((state == FCS) && load) fcs_idx <= fcs_idx + 2'd1;
      else if (state != FCS)      fcs_idx <= 2'd0;

      // Closing byte: remember the length and park counter/CRC at their start values.
      if (out_load && eof_d) begin
        len_q <= len_d;
        count <= 11'd0;
        crc   <= CRC_INIT;
      end
    end
  end

endmodule

// File: tb/tb_tx_fcs_pad.sv
// tb_tx_fcs_pad: randomized bench for tx_fcs_pad against a queue-based frame model.
module tb_tx_fcs_pad;
  localparam int MIN_LEN = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_eof, in_ready;
  logic        cfg_pad_en, cfg_crc_en;
  logic [7:0]  out_data;
  logic        out_valid, out_eof, out_ready;
  logic        frame_done;
  logic [10:0] frame_len;

  int total = 0;
  int bad   = 0;

  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];

  tx_fcs_pad #(.MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_eof(in_eof), .in_ready(in_ready),
    .cfg_pad_en(cfg_pad_en), .cfg_crc_en(cfg_crc_en),
    .out_data(out_data), .out_valid(out_valid), .out_eof(out_eof), .out_ready(out_ready),
    .frame_done(frame_done), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected wire bytes: payload, zero fill to MIN_LEN, then inverted CRC LSB first.
  function automatic void build_exp(input bit pad, input bit crc);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    exp_q = in_q;
    if (pad) while (exp_q.size() < MIN_LEN) exp_q.push_back(8'h00);
    if (crc) begin
      foreach (exp_q[i]) begin
        c = c ^ {24'd0, exp_q[i]};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    end
  endfunction

  function automatic void fill_rand(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(8'($urandom));
  endfunction

  function automatic void fill_ascii();
    in_q.delete();
    for (int i = 0; i < 9; i++) in_q.push_back(8'h31 + 8'(i));
    exp_q = in_q;
    exp_q.push_back(8'h26); exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_eof = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst/out_valid", out_valid, 0);
    chk("rst/out_eof", out_eof, 0);
    chk("rst/out_data", out_data, 0);
    chk("rst/frame_done", frame_done, 0);
    chk("rst/frame_len", frame_len, 0);
    chk("rst/in_ready", in_ready, 1);
  endtask

  // Drive in_q, collect output and compare to exp_q. abort>0 stops after that many inputs.
  task automatic run_frame(input string name, input bit pad, input bit crc,
                           input bit rnd, input int abort);
    int n, in_i, out_i, cyc, viol;
    bit done, eof_in, stall;
    logic [8:0] held;
    n = in_q.size(); in_i = 0; out_i = 0; cyc = 0; viol = 0;
    done = 0; eof_in = 0; stall = 0; held = '0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (stall) chk({name, "/hold"}, {out_valid, out_eof, out_data}, {1'b1, held});
      if (frame_done) begin
        done = 1;
        chk({name, "/frame_len"}, frame_len, exp_q.size());
        chk({name, "/out_cnt"}, out_i, exp_q.size());
        break;
      end
      if (abort > 0 && in_i == abort) break;
      out_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid   = (in_i < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data    = (in_i < n) ? in_q[in_i] : 8'h00;
      in_eof     = (in_i == n - 1);
      cfg_pad_en = (in_i == 0) ? pad : 1'($urandom);
      cfg_crc_en = (in_i == 0) ? crc : 1'($urandom);
      #1;
      if (eof_in && exp_q.size() > n && out_i < exp_q.size() - 1 && in_ready) viol++;
      if (in_valid && in_ready) begin
        if (in_eof) eof_in = 1;
        in_i++;
      end
      stall = out_valid && !out_ready;
      held  = {out_eof, out_data};
      if (out_valid && out_ready) begin
        if (out_i < exp_q.size()) begin
          chk({name, "/byte"}, out_data, exp_q[out_i]);
          chk({name, "/eof"}, out_eof, (out_i == exp_q.size() - 1));
        end else begin
          chk({name, "/extra"}, out_i, exp_q.size());
        end
        out_i++;
      end
    end
    in_valid = 1'b0;
    in_eof   = 1'b0;
    if (abort == 0) begin
      chk({name, "/done"}, done, 1);
      if (exp_q.size() > n) chk({name, "/rdy_low"}, viol, 0);
    end
  endtask

  initial begin
    int seen;
    bit p, c;
    rst_n = 1'b0; in_valid = 1'b0; in_eof = 1'b0; in_data = 8'h00;
    out_ready = 1'b1; cfg_pad_en = 1'b0; cfg_crc_en = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    fill_ascii();                         run_frame("ascii", 0, 1, 0, 0);
    fill_rand(14); build_exp(1, 1);       run_frame("pad14", 1, 1, 0, 0);
    chk("pad14/len", exp_q.size(), 64);
    fill_rand(60); build_exp(1, 1);       run_frame("len60", 1, 1, 0, 0);
    fill_rand(61); build_exp(1, 1);       run_frame("len61", 1, 1, 0, 0);
    fill_rand(10); build_exp(1, 0);       run_frame("nocrc10", 1, 0, 0, 0);
    fill_rand(1);  build_exp(0, 0);       run_frame("one", 0, 0, 0, 0);
    fill_rand(14); build_exp(1, 1);       run_frame("pad14_stall", 1, 1, 1, 0);
    fill_ascii();                         run_frame("ascii_stall", 0, 1, 1, 0);

    for (int f = 0; f < 8; f++) begin
      p = 1'($urandom); c = 1'($urandom);
      fill_rand($urandom_range(1, 80)); build_exp(p, c);
      run_frame($sformatf("rnd%0d", f), p, c, 1, 0);
    end

    // Reset in the middle of a frame: it must vanish without completion.
    fill_rand(40); build_exp(0, 1);
    run_frame("abort", 0, 1, 0, 20);
    do_reset();
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done || out_eof) seen++;
    end
    chk("abort/no_done", seen, 0);
    fill_ascii();                         run_frame("after_rst", 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
